// File: rtl/udma_hyper_ch_arbiter.sv
// -----------------------------------------------------------------------------
// udma_hyper_ch_arbiter
//
// Shares one HyperBus PHY / transaction engine among NB_CH uDMA hyper
// channels. Requests are served round-robin. A grant is held for the whole
// transaction, from the PHY start handshake to the PHY done pulse. After each
// transaction, a programmable read/write recovery gap is inserted before the
// next transaction can start.
//
// Optional feature (compile-time macro HYPER_ARB_TIMEOUT_EN):
//   A 32-bit watchdog aborts a transaction that stays in BUSY for
//   TIMEOUT_CYCLES cycles without phy_done_i. When the macro is not defined,
//   timeout_o is tied low and BUSY waits for done indefinitely.
//
// Parameters
//   NB_CH           number of requesting channels (>= 2)
//   ID_W            grant index width, $clog2(NB_CH)
//   TIMEOUT_CYCLES  watchdog limit in BUSY (used only with HYPER_ARB_TIMEOUT_EN)
//
// Ports
//   clk_i                        in   clock
//   rst_i                        in   synchronous reset, active-high
//   req_i[NB_CH]                 in   level request per channel
//   gnt_o[NB_CH]                 out  one-hot grant
//   gnt_id_o[ID_W]               out  index of the granted channel
//   phy_valid_o                  out  transaction start request to the PHY
//   phy_ready_i                  in   PHY accepts the start request
//   phy_done_i                   in   PHY finished the transaction (1-cycle pulse)
//   cfg_t_read_write_recovery_i  in   recovery gap in cycles
//   busy_vec_o[NB_CH]            out  per-channel busy flag
//   timeout_o                    out  1-cycle pulse on watchdog abort
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module udma_hyper_ch_arbiter #(
    parameter int NB_CH          = 2,
    parameter int ID_W           = $clog2(NB_CH),
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NB_CH-1:0] req_i,
    output logic [NB_CH-1:0] gnt_o,
    output logic [ID_W-1:0]  gnt_id_o,
    output logic             phy_valid_o,
    input  logic             phy_ready_i,
    input  logic             phy_done_i,
    input  logic [31:0]      cfg_t_read_write_recovery_i,
    output logic [NB_CH-1:0] busy_vec_o,
    output logic             timeout_o
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY,
        RECOV
    } state_t;

    state_t           state, state_n;
    logic [NB_CH-1:0] gnt_n;
    logic [NB_CH-1:0] busy_n;
    logic [ID_W-1:0]  gnt_id_n;
    logic             phy_valid_n;
    logic [ID_W-1:0]  ptr, ptr_n;       // last channel that started a transaction
    logic [31:0]      cnt, cnt_n;       // recovery countdown
    logic             release_grant;

    // Round-robin winner search
    logic [ID_W-1:0]  win_id;
    logic             win_found;
    logic [ID_W-1:0]  idx;

`ifdef HYPER_ARB_TIMEOUT_EN
    logic [31:0]      wdog, wdog_n;
    logic             timeout_q, timeout_n;
`endif

    // -------------------------------------------------------------------------
    // Winner: first requesting channel scanning upward from ptr+1, modulo NB_CH.
    // The pointer alone orders simultaneous requests, so after channel NB_CH-1
    // wins, channel 0 has top priority.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable written here gets a default first so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        win_found = 1'b0;
        win_id    = '0;
        idx       = '0;
        for (int i = 1; i <= NB_CH; i++) begin
            idx = ID_W'((int'(ptr) + i) % NB_CH);
            if (!win_found && req_i[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_n       = state;
        gnt_n         = gnt_o;
        gnt_id_n      = gnt_id_o;
        phy_valid_n   = phy_valid_o;
        busy_n        = busy_vec_o;
        ptr_n         = ptr;
        cnt_n         = cnt;
        release_grant = 1'b0;
`ifdef HYPER_ARB_TIMEOUT_EN
        wdog_n        = wdog;
        timeout_n     = 1'b0;
`endif

        case (state)
            IDLE: begin
                if (win_found) begin
                    gnt_n       = NB_CH'(1) << win_id;
                    busy_n      = NB_CH'(1) << win_id;
                    gnt_id_n    = win_id;
                    phy_valid_n = 1'b1;
                    state_n     = ISSUE;
                end
            end

            // Grant is committed: a requester dropping req_i here does not
            // withdraw it. The pointer only moves once the PHY has accepted.
            ISSUE: begin
                if (phy_ready_i) begin
                    phy_valid_n = 1'b0;
                    ptr_n       = gnt_id_o;
                    state_n     = BUSY;
`ifdef HYPER_ARB_TIMEOUT_EN
                    wdog_n      = '0;
`endif
                end
            end

            // phy_done_i is only looked at here; stray pulses elsewhere are ignored.
            BUSY: begin
                if (phy_done_i) begin
                    release_grant = 1'b1;
`ifdef HYPER_ARB_TIMEOUT_EN
                end else if (wdog == 32'(TIMEOUT_CYCLES - 1)) begin
                    // Expiry on the TIMEOUT_CYCLES-th BUSY cycle; done has priority.
                    release_grant = 1'b1;
                    timeout_n     = 1'b1;
                end else begin
                    wdog_n        = wdog + 32'd1;
`endif
                end

                if (release_grant) begin
                    gnt_n   = '0;
                    busy_n  = '0;
                    cnt_n   = cfg_t_read_write_recovery_i;
                    state_n = (cfg_t_read_write_recovery_i == 32'd0) ? IDLE : RECOV;
                end
            end

            // RECOV lasts exactly cnt cycles. Requests wait until IDLE.
            RECOV: begin
                if (cnt != 32'd0) begin
                    cnt_n = cnt - 32'd1;
                end
                if (cnt <= 32'd1) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before this edge, independent of statement order.
        if (rst_i) begin
            state       <= IDLE;
            gnt_o       <= '0;
            gnt_id_o    <= '0;
            phy_valid_o <= 1'b0;
            busy_vec_o  <= '0;
            ptr         <= ID_W'(NB_CH - 1);
            cnt         <= '0;
`ifdef HYPER_ARB_TIMEOUT_EN
            wdog        <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            gnt_o       <= gnt_n;
            gnt_id_o    <= gnt_id_n;
            phy_valid_o <= phy_valid_n;
            busy_vec_o  <= busy_n;
            ptr         <= ptr_n;
            cnt         <= cnt_n;
`ifdef HYPER_ARB_TIMEOUT_EN
            wdog        <= wdog_n;
            timeout_q   <= timeout_n;
`endif
        end
    end

`ifdef HYPER_ARB_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule
